// File: rtl/mcpu_ctrl_if.sv
// Control bundle between the MCPU control unit and its datapath.
// The master side is the control unit; the slave side is the datapath.
interface mcpu_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             memin;
  logic             pc_we;
  logic             ir_we;
  logic             mdr_we;
  logic             a_we;
  logic             b_we;
  logic             reg_we;
  logic [1:0]       dst;
  logic [1:0]       regin;
  logic [1:0]       alusrca;
  logic [1:0]       alusrcb;
  logic [2:0]       aluop;
  logic [1:0]       pcsrc;
  logic [3:0]       state;
  logic             halted;
  logic [1:0]       fault;
  logic [CNT_W-1:0] instret;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_we, memin, pc_we, ir_we, mdr_we, a_we, b_we, reg_we,
           dst, regin, alusrca, alusrcb, aluop, pcsrc, state, halted, fault, instret
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_we, memin, pc_we, ir_we, mdr_we, a_we, b_we, reg_we,
           dst, regin, alusrca, alusrcb, aluop, pcsrc, state, halted, fault, instret
  );
endinterface

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MCPU control FSM: decodes IR, sequences datapath enables/selects,
// handles variable-latency memory with timeout, traps illegal opcodes, counts retires.
module mcpu_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32,
  parameter bit          EN_JAL      = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  mcpu_ctrl_if.master bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ     = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                         OP_XORI    = 6'h0E, OP_LW  = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22, F_SLT = 6'h2A;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_XOR = 3'b010, ALU_SLT = 3'b011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
    S_MEM_ADDR = 4'd4,  S_MEM_RD = 4'd5,  S_MEM_WR = 4'd6,  S_WB_ALU = 4'd7,
    S_WB_MEM   = 4'd8,  S_BRANCH = 4'd9,  S_JUMP   = 4'd10, S_HALT   = 4'd11
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   instret_q;
  logic               halted_q;
  logic [1:0]         fault_q, fault_d;
  logic               dst_rt_q, dst_rt_d;
  logic               retire;
  logic               illegal;
  logic               mem_state;
  logic               timeout;
  logic [5:0]         opcode, funct;
  logic               unused_instr;

  assign opcode       = bus.instr[31:26];
  assign funct        = bus.instr[5:0];
  assign unused_instr = ^bus.instr[25:6];

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout   = (MEM_TIMEOUT != 0) && mem_state && !bus.mem_ready && (wait_q == WAIT_LAST);

  assign bus.state   = state_q;
  assign bus.halted  = halted_q;
  assign bus.fault   = fault_q;
  assign bus.instret = instret_q;

  // Next-state and datapath control decode
  always_comb begin
    state_d     = state_q;
    fault_d     = 2'd0;
    dst_rt_d    = dst_rt_q;
    retire      = 1'b0;
    illegal     = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.memin   = 1'b0;
    bus.pc_we   = 1'b0;
    bus.ir_we   = 1'b0;
    bus.mdr_we  = 1'b0;
    bus.a_we    = 1'b0;
    bus.b_we    = 1'b0;
    bus.reg_we  = 1'b0;
    bus.dst     = 2'd0;
    bus.regin   = 2'd0;
    bus.alusrca = 2'd0;
    bus.alusrcb = 2'd0;
    bus.aluop   = ALU_ADD;
    bus.pcsrc   = 2'd0;

    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.alusrcb = 2'd3;
        bus.pcsrc   = 2'd2;
        if (timeout) begin
          state_d = S_HALT;
          fault_d = 2'd2;
        end else if (bus.mem_ready) begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.a_we = 1'b1;
        bus.b_we = 1'b1;
        case (opcode)
          OP_SPECIAL: begin
            if (funct == F_ADD || funct == F_SUB || funct == F_SLT) state_d = S_EXEC_R;
            else if (EN_JAL && funct == F_JR)                       state_d = S_JUMP;
            else                                                     illegal = 1'b1;
          end
          OP_ADDI, OP_XORI: state_d = S_EXEC_I;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL: begin
            if (EN_JAL) state_d = S_JUMP;
            else        illegal = 1'b1;
          end
          default:          illegal = 1'b1;
        endcase
        if (illegal) begin
          state_d = S_HALT;
          fault_d = 2'd1;
        end
      end
      S_EXEC_R: begin
        bus.alusrca = 2'd1;
        bus.alusrcb = 2'd2;
        case (funct)
          F_SUB:   bus.aluop = ALU_SUB;
          F_SLT:   bus.aluop = ALU_SLT;
          default: bus.aluop = ALU_ADD;
        endcase
        dst_rt_d = 1'b0;
        state_d  = S_WB_ALU;
      end
      S_EXEC_I: begin
        bus.alusrca = 2'd1;
        bus.alusrcb = 2'd1;
        bus.aluop   = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
        dst_rt_d    = 1'b1;
        state_d     = S_WB_ALU;
      end
      S_WB_ALU: begin
        bus.reg_we = 1'b1;
        bus.regin  = 2'd1;
        bus.dst    = {1'b0, dst_rt_q};
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        bus.alusrca = 2'd1;
        bus.alusrcb = 2'd1;
        state_d     = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.memin   = 1'b1;
        if (timeout) begin
          state_d = S_HALT;
          fault_d = 2'd2;
        end else if (bus.mem_ready) begin
          bus.mdr_we = 1'b1;
          state_d    = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        bus.reg_we = 1'b1;
        bus.dst    = 2'd1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.memin   = 1'b1;
        if (timeout) begin
          state_d = S_HALT;
          fault_d = 2'd2;
        end else if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        bus.alusrca = 2'd1;
        bus.alusrcb = 2'd2;
        bus.aluop   = ALU_SUB;
        bus.pc_we   = (opcode == OP_BNE) ? ~bus.zero : bus.zero;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_we = 1'b1;
        if (opcode == OP_SPECIAL) begin
          bus.pcsrc = 2'd3;
        end else begin
          bus.pcsrc = 2'd1;
          if (opcode == OP_JAL) begin
            bus.reg_we = 1'b1;
            bus.dst    = 2'd2;
            bus.regin  = 2'd2;
          end
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        fault_d = 2'd1;
      end
    endcase

    // Wait counter restarts whenever a new state is entered
    if (state_d != state_q)               wait_d = '0;
    else if (mem_state && !bus.mem_ready) wait_d = wait_q + WAIT_W'(1);
    else                                  wait_d = wait_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 2'd0;
      dst_rt_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      dst_rt_q <= dst_rt_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
      if (state_d == S_HALT && state_q != S_HALT) begin
        halted_q <= 1'b1;
        fault_q  <= fault_d;
      end
    end
  end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed bench for mcpu_ctrl: vector table of single instructions plus
// hand sequences for memory waits, timeout, illegal opcodes, reset and EN_JAL=0.
module tb_mcpu_ctrl;

  localparam logic [3:0] ST_F  = 4'd0, ST_D  = 4'd1, ST_ER = 4'd2, ST_EI = 4'd3,
                         ST_MA = 4'd4, ST_MR = 4'd5, ST_MW = 4'd6, ST_WA = 4'd7,
                         ST_WM = 4'd8, ST_BR = 4'd9, ST_JP = 4'd10, ST_H = 4'd11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mcpu_ctrl_if #(.CNT_W(32)) bus ();
  mcpu_ctrl_if #(.CNT_W(2))  bus2 ();

  mcpu_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32), .EN_JAL(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  mcpu_ctrl #(.MEM_TIMEOUT(0), .CNT_W(2), .EN_JAL(1'b0)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int unsigned ncyc;
    logic [19:0] seq;
    logic [7:0]  last;
    logic [2:0]  alu;
  } vec_t;

  vec_t vecs[14];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned exp_ret = 0;

  function automatic logic [19:0] seq5(input logic [3:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  function automatic logic [7:0] lst(input logic pw, rw, input logic [1:0] ds, rg, ps);
    return {pw, rw, ds, rg, ps};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one instruction with zero-wait memory, starting just after a negedge in FETCH
  task automatic run_vec(input int idx, input vec_t v);
    logic [19:0] trace;
    logic [7:0]  last;
    logic [2:0]  alu;
    int unsigned n;
    trace = '0; last = '0; alu = '0; n = 0;
    bus.instr = v.instr;
    bus.zero = v.zero;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k > 0 && bus.state == ST_F) break;
      if (k < 5) trace[4*k +: 4] = bus.state;
      n++;
      last = {bus.pc_we, bus.reg_we, bus.dst, bus.regin, bus.pcsrc};
      if (k == 2) alu = bus.aluop;
      @(negedge clk);
    end
    exp_ret++;
    chk($sformatf("v%0d_cycles", idx), 32'(n), 32'(v.ncyc));
    chk($sformatf("v%0d_states", idx), 32'(trace), 32'(v.seq));
    chk($sformatf("v%0d_last_ctl", idx), 32'(last), 32'(v.last));
    chk($sformatf("v%0d_aluop", idx), 32'(alu), 32'(v.alu));
    chk($sformatf("v%0d_instret", idx), bus.instret, exp_ret);
  endtask

  initial begin
    int unsigned total, rd, mdr, waits, fcyc, irs;

    vecs[0]  = '{32'h20090005, 1'b0, 4, seq5(ST_F, ST_D, ST_EI, ST_WA, ST_F), lst(1'b0, 1'b1, 2'd1, 2'd1, 2'd0), 3'b000};
    vecs[1]  = '{32'h012A4020, 1'b0, 4, seq5(ST_F, ST_D, ST_ER, ST_WA, ST_F), lst(1'b0, 1'b1, 2'd0, 2'd1, 2'd0), 3'b000};
    vecs[2]  = '{32'h012A4022, 1'b0, 4, seq5(ST_F, ST_D, ST_ER, ST_WA, ST_F), lst(1'b0, 1'b1, 2'd0, 2'd1, 2'd0), 3'b001};
    vecs[3]  = '{32'h012A402A, 1'b0, 4, seq5(ST_F, ST_D, ST_ER, ST_WA, ST_F), lst(1'b0, 1'b1, 2'd0, 2'd1, 2'd0), 3'b011};
    vecs[4]  = '{32'h392900FF, 1'b0, 4, seq5(ST_F, ST_D, ST_EI, ST_WA, ST_F), lst(1'b0, 1'b1, 2'd1, 2'd1, 2'd0), 3'b010};
    vecs[5]  = '{32'h8D090004, 1'b0, 5, seq5(ST_F, ST_D, ST_MA, ST_MR, ST_WM), lst(1'b0, 1'b1, 2'd1, 2'd0, 2'd0), 3'b000};
    vecs[6]  = '{32'hAD090004, 1'b0, 4, seq5(ST_F, ST_D, ST_MA, ST_MW, ST_F), lst(1'b0, 1'b0, 2'd0, 2'd0, 2'd0), 3'b000};
    vecs[7]  = '{32'h11090003, 1'b1, 3, seq5(ST_F, ST_D, ST_BR, ST_F, ST_F), lst(1'b1, 1'b0, 2'd0, 2'd0, 2'd0), 3'b001};
    vecs[8]  = '{32'h15090003, 1'b1, 3, seq5(ST_F, ST_D, ST_BR, ST_F, ST_F), lst(1'b0, 1'b0, 2'd0, 2'd0, 2'd0), 3'b001};
    vecs[9]  = '{32'h11090003, 1'b0, 3, seq5(ST_F, ST_D, ST_BR, ST_F, ST_F), lst(1'b0, 1'b0, 2'd0, 2'd0, 2'd0), 3'b001};
    vecs[10] = '{32'h15090003, 1'b0, 3, seq5(ST_F, ST_D, ST_BR, ST_F, ST_F), lst(1'b1, 1'b0, 2'd0, 2'd0, 2'd0), 3'b001};
    vecs[11] = '{32'h08000010, 1'b0, 3, seq5(ST_F, ST_D, ST_JP, ST_F, ST_F), lst(1'b1, 1'b0, 2'd0, 2'd0, 2'd1), 3'b000};
    vecs[12] = '{32'h0C000010, 1'b0, 3, seq5(ST_F, ST_D, ST_JP, ST_F, ST_F), lst(1'b1, 1'b1, 2'd2, 2'd2, 2'd1), 3'b000};
    vecs[13] = '{32'h03E00008, 1'b0, 3, seq5(ST_F, ST_D, ST_JP, ST_F, ST_F), lst(1'b1, 1'b0, 2'd0, 2'd0, 2'd3), 3'b000};

    reset = 1'b0;
    bus.instr = '0;  bus.zero = 1'b0;  bus.mem_ready = 1'b0;
    bus2.instr = '0; bus2.zero = 1'b0; bus2.mem_ready = 1'b0;
    #12;
    chk("rst_state", 32'(bus.state), 32'(ST_F));
    chk("rst_mem_req", 32'(bus.mem_req), 32'd1);
    chk("rst_ir_we", 32'(bus.ir_we), 32'd0);
    chk("rst_pc_we", 32'(bus.pc_we), 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // lw with three wait cycles in MEM_RD
    bus.instr = 32'h8D090004;
    total = 0; rd = 0; mdr = 0; waits = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (k > 0 && bus.state == ST_F) break;
      total++;
      if (bus.state == ST_MR) begin
        rd++;
        bus.mem_ready = (waits < 3) ? 1'b0 : 1'b1;
        if (!bus.mem_ready) waits++;
      end else begin
        bus.mem_ready = 1'b1;
      end
      #1;
      if (bus.mdr_we) mdr++;
      @(negedge clk);
    end
    exp_ret++;
    chk("lw_wait_cycles", 32'(total), 32'd8);
    chk("lw_wait_memrd", 32'(rd), 32'd4);
    chk("lw_wait_mdr_pulses", 32'(mdr), 32'd1);
    chk("lw_wait_instret", bus.instret, exp_ret);

    // Illegal opcode traps, then asynchronous reset out of HALT
    bus.instr = 32'hFC000000;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("ill_state", 32'(bus.state), 32'(ST_H));
    chk("ill_fault", 32'(bus.fault), 32'd1);
    chk("ill_halted", 32'(bus.halted), 32'd1);
    chk("ill_instret", bus.instret, exp_ret);
    chk("ill_mem_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    #1;
    chk("ill_stay", 32'(bus.state), 32'(ST_H));
    chk("ill_no_en", 32'({bus.pc_we, bus.ir_we, bus.reg_we, bus.a_we}), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_state", 32'(bus.state), 32'(ST_F));
    chk("arst_fault", 32'(bus.fault), 32'd0);
    chk("arst_instret", bus.instret, 32'd0);
    chk("arst_halted", 32'(bus.halted), 32'd0);

    // Fetch timeout with mem_ready held low
    bus.mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fcyc = 0; irs = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.state == ST_H) break;
      fcyc++;
      if (bus.ir_we || bus.pc_we) irs++;
      @(negedge clk);
    end
    chk("to_fetch_cycles", 32'(fcyc), 32'd16);
    chk("to_state", 32'(bus.state), 32'(ST_H));
    chk("to_fault", 32'(bus.fault), 32'd2);
    chk("to_halted", 32'(bus.halted), 32'd1);
    chk("to_no_ir_we", 32'(irs), 32'd0);
    chk("to_mem_req", 32'(bus.mem_req), 32'd0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("to_halt_ignores_ready", 32'({bus.state, bus.ir_we, bus.pc_we}), 32'({ST_H, 2'b00}));
    chk("notimeout_state", 32'(bus2.state), 32'(ST_F));
    chk("notimeout_fault", 32'(bus2.fault), 32'd0);

    // EN_JAL=0 instance: j is legal and instret wraps at 2 bits; jal/jr trap
    reset = 1'b0;
    bus2.instr = 32'h08000010;
    bus2.mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    chk("d2_j_state", 32'(bus2.state), 32'(ST_F));
    chk("d2_instret_wrap", 32'(bus2.instret), 32'd1);
    bus2.instr = 32'h0C000010;
    repeat (2) @(negedge clk);
    #1;
    chk("d2_jal_state", 32'(bus2.state), 32'(ST_H));
    chk("d2_jal_fault", 32'(bus2.fault), 32'd1);
    reset = 1'b0;
    bus2.instr = 32'h03E00008;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("d2_jr_state", 32'(bus2.state), 32'(ST_H));
    chk("d2_jr_fault", 32'(bus2.fault), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
